// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller and the RV64
// subset datapath it drives.
//   - state_t       : controller state encoding (also exported on state_dbg)
//   - instr_class_t : instruction class produced by instr_class_decode
//   - opcode/funct  : field values of the supported instructions
//   - mux/ALU codes : alu_op, alu_src_b, pc_src, wb_sel encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_ALU_WB   = 4'd5,
    ST_LUI_WB   = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_LD_READ  = 4'd8,
    ST_LD_WB    = 4'd9,
    ST_SD_WRITE = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LD      = 3'd2,
    CLS_SD      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_BNE     = 3'd5,
    CLS_LUI     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_PASSB = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_PC4    = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_IMM    = 2'd2;

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational classification of the IR fields into one
// of the supported instruction classes, or CLS_ILLEGAL.
//   opcode/funct3/funct7 in : IR[6:0], IR[14:12], IR[31:25]
//   instr_class          out: decoded class
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t instr_class
);

  // Opcode/funct dispatch; any field combination not listed is illegal.
  always_comb begin
    instr_class = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        if ((funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB))) begin
          instr_class = CLS_R;
        end else begin
          instr_class = CLS_ILLEGAL;
        end
      end
      OP_IMM: begin
        if (funct3 == F3_ADD) instr_class = CLS_I;
        else                  instr_class = CLS_ILLEGAL;
      end
      OP_LOAD: begin
        if (funct3 == F3_DWORD) instr_class = CLS_LD;
        else                    instr_class = CLS_ILLEGAL;
      end
      OP_STORE: begin
        if (funct3 == F3_DWORD) instr_class = CLS_SD;
        else                    instr_class = CLS_ILLEGAL;
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ)      instr_class = CLS_BEQ;
        else if (funct3 == F3_BNE) instr_class = CLS_BNE;
        else                       instr_class = CLS_ILLEGAL;
      end
      OP_LUI:  instr_class = CLS_LUI;
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/write-back
// for the RV64 subset multicycle datapath.
//   MEM_WAIT               : extra cycles a memory read needs (0..15)
//   clk, reset             : rising-edge clock, async active-high reset
//   opcode/funct3/funct7   : IR fields
//   zero                   : ALU result == 0 (used only in BRANCH)
//   *_we, iord, alu_src_*, alu_op, pc_src, wb_sel : datapath controls
//   illegal                : sticky trap flag
//   state_dbg              : current state encoding
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       regfile_we,
  output logic       a_we,
  output logic       b_we,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       dmem_we,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] WAIT_C = 4'(MEM_WAIT);

  state_t       state_r, next_state_s;
  logic [3:0]   cnt_r, cnt_next_s;
  instr_class_t cls_s;
  logic         wait_done_s;
  logic         taken_s;

  instr_class_decode u_decode (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .instr_class (cls_s)
  );

  assign wait_done_s = (cnt_r == WAIT_C);
  // bne inverts the sense of the ALU zero flag.
  assign taken_s     = (cls_s == CLS_BNE) ? ~zero : zero;
  assign state_dbg   = state_r;

  // State and memory-wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RST;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter update; counter only runs in the two memory-read states.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = 4'd0;
    case (state_r)
      ST_RST:    next_state_s = ST_FETCH;
      ST_FETCH: begin
        if (wait_done_s) begin
          next_state_s = ST_DECODE;
          cnt_next_s   = 4'd0;
        end else begin
          next_state_s = ST_FETCH;
          cnt_next_s   = cnt_r + 4'd1;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CLS_R:   next_state_s = ST_EXEC_R;
          CLS_I:   next_state_s = ST_EXEC_I;
          CLS_LD:  next_state_s = ST_MEM_ADDR;
          CLS_SD:  next_state_s = ST_MEM_ADDR;
          CLS_BEQ: next_state_s = ST_BRANCH;
          CLS_BNE: next_state_s = ST_BRANCH;
          CLS_LUI: next_state_s = ST_LUI_WB;
          default: next_state_s = ST_TRAP;
        endcase
      end
      ST_EXEC_R:   next_state_s = ST_ALU_WB;
      ST_EXEC_I:   next_state_s = ST_ALU_WB;
      ST_MEM_ADDR: begin
        if (cls_s == CLS_LD)      next_state_s = ST_LD_READ;
        else if (cls_s == CLS_SD) next_state_s = ST_SD_WRITE;
        else                      next_state_s = ST_TRAP;
      end
      ST_LD_READ: begin
        if (wait_done_s) begin
          next_state_s = ST_LD_WB;
          cnt_next_s   = 4'd0;
        end else begin
          next_state_s = ST_LD_READ;
          cnt_next_s   = cnt_r + 4'd1;
        end
      end
      ST_ALU_WB:   next_state_s = ST_FETCH;
      ST_LUI_WB:   next_state_s = ST_FETCH;
      ST_LD_WB:    next_state_s = ST_FETCH;
      ST_SD_WRITE: next_state_s = ST_FETCH;
      ST_BRANCH:   next_state_s = ST_FETCH;
      ST_TRAP:     next_state_s = ST_TRAP;
      default:     next_state_s = ST_TRAP;
    endcase
  end

  // Moore output decode from state (plus counter in read states, zero in BRANCH).
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    regfile_we = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    aluout_we  = 1'b0;
    mdr_we     = 1'b0;
    dmem_we    = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    wb_sel     = WB_ALUOUT;
    illegal    = 1'b0;
    case (state_r)
      ST_FETCH: ir_we = wait_done_s;
      ST_DECODE: begin
        // Speculative branch target PC+imm lands in ALUOut.
        a_we      = 1'b1;
        b_we      = 1'b1;
        aluout_we = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = funct7[5] ? ALU_SUB : ALU_ADD;
        aluout_we = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluout_we = 1'b1;
      end
      ST_ALU_WB, ST_LUI_WB, ST_LD_WB: begin
        regfile_we = 1'b1;
        pc_we      = 1'b1;
        pc_src     = PCSRC_PC4;
        if (state_r == ST_LUI_WB)     wb_sel = WB_IMM;
        else if (state_r == ST_LD_WB) wb_sel = WB_MDR;
        else                          wb_sel = WB_ALUOUT;
      end
      ST_LD_READ: begin
        iord   = 1'b1;
        mdr_we = wait_done_s;
      end
      ST_SD_WRITE: begin
        iord    = 1'b1;
        dmem_we = 1'b1;
        pc_we   = 1'b1;
        pc_src  = PCSRC_PC4;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_we     = 1'b1;
        pc_src    = taken_s ? PCSRC_ALUOUT : PCSRC_PC4;
      end
      ST_TRAP: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the RV64 subset datapath (PC, IR, register file, A/B, ALU, ALUOut, MDR, immediate sign-extension, single-port memory). A Moore FSM sequences fetch, decode, execute, memory and write-back, producing every register write enable and mux select. A wait counter absorbs a fixed memory read latency. Illegal or unsupported instructions park the machine in a sticky trap.

## Interface
- MEM_WAIT, 2, extra cycles a memory read needs before its data is valid (0..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU result == 0, combinational from datapath
- pc_we, ir_we, regfile_we, a_we, b_we, aluout_we, mdr_we, dmem_we  out  1 each  register/memory write enables
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  0 B, 1 const 4, 2 sign-extended immediate
- alu_op  out  2  0 add, 1 sub, 2 pass B
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 PC+4 (datapath incrementer)
- wb_sel  out  2  0 ALUOut, 1 MDR, 2 immediate (LUI)
- illegal  out  1  sticky trap flag
- state_dbg  out  4  current state encoding

## Operation
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, LUI_WB, MEM_ADDR, LD_READ, LD_WB, SD_WRITE, BRANCH, TRAP.
- Defaults every state: all enables 0, selects 0, alu_op add.
- RST: all outputs 0, illegal 0; -> FETCH.
- FETCH: iord=0; wait counter runs 0..MEM_WAIT; on count==MEM_WAIT assert ir_we, -> DECODE; counter cleared on exit.
- DECODE: a_we, b_we; aluout_we with PC+imm (alu_src_a=0, alu_src_b=2). Dispatch on opcode:
  - 0110011 funct3 000, funct7 0000000 (add) / 0100000 (sub) -> EXEC_R
  - 0010011 funct3 000 (addi) -> EXEC_I
  - 0000011 funct3 011 (ld), 0100011 funct3 011 (sd) -> MEM_ADDR
  - 1100011 funct3 000 (beq) / 001 (bne) -> BRANCH
  - 0110111 (lui) -> LUI_WB
  - anything else -> TRAP
- EXEC_R: A op B (sub when funct7[5]), aluout_we -> ALU_WB. EXEC_I: A+imm, aluout_we -> ALU_WB.
- ALU_WB: regfile_we, wb_sel=0, pc_we pc_src=2 -> FETCH.
- LUI_WB: regfile_we, wb_sel=2, pc_we pc_src=2 -> FETCH.
- MEM_ADDR: A+imm, aluout_we; -> LD_READ (ld) or SD_WRITE (sd).
- LD_READ: iord=1; counter 0..MEM_WAIT; at MEM_WAIT mdr_we -> LD_WB. LD_WB: regfile_we, wb_sel=1, pc_we pc_src=2 -> FETCH.
- SD_WRITE: iord=1, dmem_we, pc_we pc_src=2 -> FETCH.
- BRANCH: A-B (alu_op sub); taken = zero (beq) or !zero (bne); pc_we=1, pc_src = taken ? 1 : 2 -> FETCH.
- TRAP: illegal=1, all enables 0; stays until reset.

## Timing
- Registered state and counter; outputs decoded from state (+counter, zero) with no added latency.
- Cycles per instruction (W=MEM_WAIT): beq/bne, lui W+3; add/sub/addi, sd W+4; ld 2W+5.
- Exactly one pc_we pulse per retired instruction, in its final state; never pc_we in FETCH/DECODE.
- Reset asserted mid-instruction: state to RST and counter to 0 immediately, all outputs 0 asynchronously; first FETCH one clock after reset deasserts.
- zero sampled only in BRANCH; its value in other states is ignored.
- MEM_WAIT=0: FETCH and LD_READ last one cycle each.

## Structure
- ctrl_pkg: state enum, opcode/funct constants, alu_op, alu_src_b, pc_src, wb_sel codes, shared with datapath.
- One sub-module natural: instr_class_decode (combinational opcode/funct3/funct7 -> class enum incl. ILLEGAL), used by DECODE dispatch.

## Test plan
- Reset then addi (opcode 0010011, f3 000), MEM_WAIT=2 -> ir_we in cycle 3, regfile_we + pc_we(pc_src=2) in cycle 6, no other writes.
- ld (0000011, f3 011), MEM_WAIT=2 -> mdr_we exactly 3 cycles after MEM_ADDR, regfile_we wb_sel=1, total 9 cycles.
- beq with zero=1 -> pc_src=1; bne with zero=1 -> pc_src=2; both single pc_we, total W+3 cycles.
- sd -> dmem_we=1 with iord=1 for exactly one cycle, regfile_we never asserted.
- opcode 1100111 -> TRAP, illegal=1 held 20 cycles, all enables 0; reset clears it.
- Reset asserted during LD_READ counter=1 -> outputs 0 same cycle; restart fetches with counter from 0.
